// File: rtl/axil_reg_rd_pipe.sv
// AXI-Lite read channel to register bus bridge: one read in flight, per-read timeout, response FIFO.
// Optional AXIL_RD_TIMEOUT_SLVERR_EN: timed-out reads answer {0, SLVERR} instead of {reg_rd_data, OKAY}.
module axil_reg_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 40,
  parameter int TIMEOUT    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack,
  output logic                  rd_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TIMEOUT - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [0:0]            state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [1:0]            mem_resp [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W:0]        count_reg;

  logic                  in_req;
  logic                  ar_fire;
  logic                  done_ack;
  logic                  done_to;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic [1:0]            push_resp;
  logic                  unused_arprot;

  assign unused_arprot = ^s_axil_arprot;

  assign in_req   = (state_reg == ST_REQ);
  assign done_ack = in_req && reg_rd_ack;
  assign done_to  = in_req && !reg_rd_ack && !reg_rd_wait && (cnt_reg == '0);
  assign push     = done_ack || done_to;

  // Gated by rstn so the master never sees ready while reset is held.
  assign s_axil_arready = rstn && (state_reg == ST_IDLE) && (count_reg < DEPTH_C);
  assign ar_fire        = s_axil_arvalid && s_axil_arready;

  assign s_axil_rvalid = (count_reg != '0);
  assign pop           = s_axil_rvalid && s_axil_rready;
  assign s_axil_rdata  = s_axil_rvalid ? mem_data[rd_ptr_reg] : '0;
  assign s_axil_rresp  = s_axil_rvalid ? mem_resp[rd_ptr_reg] : 2'b00;

  assign reg_rd_en   = in_req;
  assign reg_rd_addr = addr_reg;
  assign rd_timeout  = rstn && done_to;

`ifdef AXIL_RD_TIMEOUT_SLVERR_EN
  assign push_data = done_ack ? reg_rd_data : '0;
  assign push_resp = done_ack ? 2'b00 : 2'b10;
`else
  assign push_data = reg_rd_data;
  assign push_resp = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (ar_fire) begin
            addr_reg  <= s_axil_araddr;
            cnt_reg   <= CNT_INIT;
            state_reg <= ST_REQ;
          end
        end
        default: begin
          // A completion always wins; otherwise only non-wait cycles consume budget.
          if (push) begin
            state_reg <= ST_IDLE;
          end else if (!reg_rd_wait) begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_reg] <= push_data;
      mem_resp[wr_ptr_reg] <= push_resp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_rd_pipe.sv
// Self-checking bench for axil_reg_rd_pipe: directed scenarios plus randomized traffic
// checked against a transaction-level model (busy flag, remaining budget, response queue).
module tb_axil_reg_rd_pipe;

  localparam int DW = 32;
  localparam int AW = 40;
  localparam int TIMEOUT = 16;
  localparam int FIFO_DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] s_axil_araddr;
  logic [2:0]    s_axil_arprot;
  logic          s_axil_arvalid;
  logic          s_axil_arready;
  logic [DW-1:0] s_axil_rdata;
  logic [1:0]    s_axil_rresp;
  logic          s_axil_rvalid;
  logic          s_axil_rready;
  logic [AW-1:0] reg_rd_addr;
  logic          reg_rd_en;
  logic [DW-1:0] reg_rd_data;
  logic          reg_rd_wait;
  logic          reg_rd_ack;
  logic          rd_timeout;

  axil_reg_rd_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack), .rd_timeout(rd_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a read in flight has a budget of non-wait cycles left.
  bit            m_busy = 0;
  int            m_budget = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW+1:0] m_q[$];

  logic          o_arready, o_rvalid, o_en, o_to;
  logic [DW-1:0] o_rdata;
  logic [1:0]    o_rresp;
  logic [AW-1:0] o_addr;
  logic          p_arready, p_rvalid, p_en, p_to;
  logic [DW-1:0] p_rdata;
  logic [1:0]    p_rresp;
  logic [AW-1:0] p_addr;

  task automatic tick();
    logic [DW+1:0] head;
    logic          fire;
    @(negedge clk);
    o_arready = s_axil_arready; o_rvalid = s_axil_rvalid; o_rdata = s_axil_rdata;
    o_rresp = s_axil_rresp; o_en = reg_rd_en; o_addr = reg_rd_addr; o_to = rd_timeout;
    head = (m_q.size() > 0) ? m_q[0] : '0;
    p_arready = rstn && !m_busy && (m_q.size() < FIFO_DEPTH);
    p_rvalid  = (m_q.size() > 0);
    p_rdata   = head[DW+1:2];
    p_rresp   = head[1:0];
    p_en      = m_busy;
    p_addr    = m_addr;
    p_to      = rstn && m_busy && !reg_rd_ack && !reg_rd_wait && (m_budget == 1);
    @(posedge clk);
    if (!rstn) begin
      m_busy = 0; m_budget = 0; m_addr = '0; m_q.delete();
    end else begin
      fire = s_axil_arvalid && p_arready;
      if (p_rvalid && s_axil_rready) void'(m_q.pop_front());
      if (m_busy) begin
        if (reg_rd_ack) begin
          m_q.push_back({reg_rd_data, 2'b00}); m_busy = 0;
        end else if (!reg_rd_wait) begin
          m_budget--;
          if (m_budget == 0) begin
`ifdef AXIL_RD_TIMEOUT_SLVERR_EN
            m_q.push_back({{DW{1'b0}}, 2'b10});
`else
            m_q.push_back({reg_rd_data, 2'b00});
`endif
            m_busy = 0;
          end
        end
      end else if (fire) begin
        m_busy = 1; m_budget = TIMEOUT; m_addr = s_axil_araddr;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    s_axil_arvalid = 0; s_axil_araddr = '0; s_axil_arprot = 3'b0;
    s_axil_rready = 1; reg_rd_ack = 0; reg_rd_wait = 0; reg_rd_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs(); rstn = 0;
    tick(); tick();
    checks++; if (o_arready !== 1'b0) begin failures++; $display("FAIL reset_arready got=%0h exp=0", o_arready); end
    checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0h exp=0", o_rvalid); end
    checks++; if (o_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", o_rdata); end
    checks++; if (o_rresp !== 2'b00) begin failures++; $display("FAIL reset_rresp got=%0h exp=0", o_rresp); end
    checks++; if (o_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%0h exp=0", o_en); end
    checks++; if (o_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", o_addr); end
    checks++; if (o_to !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0h exp=0", o_to); end
    rstn = 1;
    tick();
    checks++; if (o_arready !== 1'b1) begin failures++; $display("FAIL reset_arready_after got=%0h exp=1", o_arready); end
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    idle_inputs();
    s_axil_arvalid = 1; s_axil_araddr = 40'h10;
    tick();
    checks++; if (o_arready !== 1'b1) begin failures++; $display("FAIL single_arready got=%0h exp=1", o_arready); end
    s_axil_arvalid = 0; reg_rd_ack = 1; reg_rd_data = 32'hDEADBEEF;
    tick();
    checks++; if (o_en !== 1'b1) begin failures++; $display("FAIL single_en got=%0h exp=1", o_en); end
    checks++; if (o_addr !== 40'h10) begin failures++; $display("FAIL single_addr got=%0h exp=10", o_addr); end
    checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL single_rvalid_early got=%0h exp=0", o_rvalid); end
    reg_rd_ack = 0; reg_rd_data = '0;
    tick();
    checks++; if (o_rvalid !== 1'b1) begin failures++; $display("FAIL single_rvalid got=%0h exp=1", o_rvalid); end
    checks++; if (o_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rdata got=%0h exp=deadbeef", o_rdata); end
    checks++; if (o_rresp !== 2'b00) begin failures++; $display("FAIL single_rresp got=%0h exp=0", o_rresp); end
    checks++; if (o_en !== 1'b0) begin failures++; $display("FAIL single_en_after got=%0h exp=0", o_en); end
    tick();
    checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL single_popped got=%0h exp=0", o_rvalid); end
    $display("test_single_read done");
  endtask

  task automatic test_fifo_full();
    idle_inputs(); s_axil_rready = 0;
    for (int i = 1; i <= 4; i++) begin
      s_axil_arvalid = 1; s_axil_araddr = AW'(i * 4);
      tick();
      checks++; if (o_arready !== 1'b1) begin failures++; $display("FAIL full_accept%0d got=%0h exp=1", i, o_arready); end
      s_axil_arvalid = 0; reg_rd_ack = 1; reg_rd_data = DW'(i);
      tick();
      reg_rd_ack = 0;
    end
    s_axil_arvalid = 1;
    tick();
    checks++; if (o_arready !== 1'b0) begin failures++; $display("FAIL full_arready got=%0h exp=0", o_arready); end
    s_axil_arvalid = 0; s_axil_rready = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (o_rvalid !== 1'b1 || o_rdata !== DW'(k)) begin failures++; $display("FAIL full_order%0d got=%0h/%0h exp=1/%0h", k, o_rvalid, o_rdata, k); end
      checks++; if (o_arready !== (k > 1)) begin failures++; $display("FAIL full_arready_pop%0d got=%0h exp=%0h", k, o_arready, k > 1); end
    end
    tick();
    checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL full_drained got=%0h exp=0", o_rvalid); end
    $display("test_fifo_full done");
  endtask

  task automatic test_timeout();
    int hit = 0;
    int pulses = 0;
    idle_inputs(); reg_rd_data = 32'hA5A50F0F;
    s_axil_arvalid = 1; s_axil_araddr = 40'h20;
    tick();
    s_axil_arvalid = 0;
    for (int c = 1; c <= 40 && hit == 0; c++) begin
      tick();
      if (o_to) begin hit = c; pulses++; end
    end
    checks++; if (hit != TIMEOUT) begin failures++; $display("FAIL timeout_cycle got=%0d exp=%0d", hit, TIMEOUT); end
    tick();
    if (o_to) pulses++;
    checks++; if (pulses != 1) begin failures++; $display("FAIL timeout_pulses got=%0d exp=1", pulses); end
    checks++; if (o_rvalid !== 1'b1) begin failures++; $display("FAIL timeout_rvalid got=%0h exp=1", o_rvalid); end
`ifdef AXIL_RD_TIMEOUT_SLVERR_EN
    checks++; if (o_rresp !== 2'b10 || o_rdata !== '0) begin failures++; $display("FAIL timeout_entry got=%0h/%0h exp=2/0", o_rresp, o_rdata); end
`else
    checks++; if (o_rresp !== 2'b00 || o_rdata !== 32'hA5A50F0F) begin failures++; $display("FAIL timeout_entry got=%0h/%0h exp=0/a5a50f0f", o_rresp, o_rdata); end
`endif
    tick();
    $display("test_timeout done");
  endtask

  task automatic test_wait();
    int en_cycles = 0;
    int to_seen = 0;
    idle_inputs();
    s_axil_arvalid = 1; s_axil_araddr = 40'h30;
    tick();
    s_axil_arvalid = 0; reg_rd_wait = 1;
    for (int c = 0; c < 100; c++) begin
      tick();
      en_cycles += int'(o_en); to_seen += int'(o_to);
    end
    reg_rd_wait = 0; reg_rd_ack = 1; reg_rd_data = 32'h1234;
    tick();
    en_cycles += int'(o_en); to_seen += int'(o_to);
    reg_rd_ack = 0;
    tick();
    checks++; if (en_cycles != 101) begin failures++; $display("FAIL wait_en_cycles got=%0d exp=101", en_cycles); end
    checks++; if (to_seen != 0) begin failures++; $display("FAIL wait_timeout got=%0d exp=0", to_seen); end
    checks++; if (o_rvalid !== 1'b1 || o_rresp !== 2'b00 || o_rdata !== 32'h1234) begin failures++; $display("FAIL wait_entry got=%0h/%0h/%0h exp=1/0/1234", o_rvalid, o_rresp, o_rdata); end
    checks++; if (o_en !== 1'b0) begin failures++; $display("FAIL wait_en_after got=%0h exp=0", o_en); end
    $display("test_wait done");
  endtask

  task automatic test_ack_at_zero();
    int to_seen = 0;
    idle_inputs();
    s_axil_arvalid = 1; s_axil_araddr = 40'h40;
    tick();
    s_axil_arvalid = 0;
    for (int c = 1; c < TIMEOUT; c++) begin
      tick();
      to_seen += int'(o_to);
    end
    reg_rd_ack = 1; reg_rd_data = 32'h5555;
    tick();
    to_seen += int'(o_to);
    reg_rd_ack = 0;
    tick();
    checks++; if (to_seen != 0) begin failures++; $display("FAIL ackzero_timeout got=%0d exp=0", to_seen); end
    checks++; if (o_rvalid !== 1'b1 || o_rresp !== 2'b00 || o_rdata !== 32'h5555) begin failures++; $display("FAIL ackzero_entry got=%0h/%0h/%0h exp=1/0/5555", o_rvalid, o_rresp, o_rdata); end
    $display("test_ack_at_zero done");
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    idle_inputs(); s_axil_rready = 0;
    for (int i = 0; i < 2; i++) begin
      s_axil_arvalid = 1; s_axil_araddr = AW'(8 * i);
      tick();
      s_axil_arvalid = 0; reg_rd_ack = 1; reg_rd_data = DW'(8'h11 * (i + 1));
      tick();
      reg_rd_ack = 0;
    end
    s_axil_arvalid = 1; s_axil_araddr = 40'h50;
    tick();
    s_axil_arvalid = 0;
    tick();
    checks++; if (o_en !== 1'b1 || o_rvalid !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%0h/%0h exp=1/1", o_en, o_rvalid); end
    rstn = 0;
    tick();
    rstn = 1; s_axil_rready = 1;
    tick();
    checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_rvalid got=%0h exp=0", o_rvalid); end
    checks++; if (o_en !== 1'b0) begin failures++; $display("FAIL midrst_en got=%0h exp=0", o_en); end
    reg_rd_ack = 1; reg_rd_data = 32'hBAD;
    for (int c = 0; c < 20; c++) begin
      tick();
      stale += int'(o_rvalid);
    end
    reg_rd_ack = 0;
    checks++; if (stale != 0) begin failures++; $display("FAIL midrst_stale got=%0d exp=0", stale); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [63:0] r64;
    int bad = 0;
    for (int c = 0; c < 1500; c++) begin
      r64 = {$urandom, $urandom};
      rstn           = ($urandom_range(0, 199) != 0);
      s_axil_arvalid = ($urandom_range(0, 1) == 1);
      s_axil_araddr  = r64[AW-1:0];
      s_axil_arprot  = 3'($urandom);
      s_axil_rready  = ($urandom_range(0, 4) < 3);
      reg_rd_ack     = ($urandom_range(0, 11) == 0);
      reg_rd_wait    = ($urandom_range(0, 2) == 0);
      reg_rd_data    = $urandom;
      tick();
      checks++;
      if (o_arready !== p_arready || o_rvalid !== p_rvalid || o_en !== p_en || o_to !== p_to ||
          o_addr !== p_addr || (p_rvalid && (o_rdata !== p_rdata || o_rresp !== p_rresp))) begin
        failures++; bad++;
        $display("FAIL random_c%0d got ar=%0h rv=%0h d=%0h r=%0h en=%0h a=%0h to=%0h exp ar=%0h rv=%0h d=%0h r=%0h en=%0h a=%0h to=%0h",
                 c, o_arready, o_rvalid, o_rdata, o_rresp, o_en, o_addr, o_to,
                 p_arready, p_rvalid, p_rdata, p_rresp, p_en, p_addr, p_to);
      end
    end
    $display("test_random done mismatching_cycles=%0d", bad);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_fifo_full();
    test_timeout();
    test_wait();
    test_ack_at_zero();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_reg_rd_pipe.md
# axil_reg_rd_pipe

AXI-Lite read-channel to register-bus bridge with a parametrised response FIFO, variable-latency register acknowledge and a per-read timeout. It sits between the AXI-Lite interconnect slave port and the accelerator's register file or status readback muxes. The R channel is decoupled from the register bus: a stalled master no longer blocks register reads that are already in flight.

## Interface
- DATA_WIDTH, 32: register/AXI data width in bits.
- ADDR_WIDTH, 40: address width in bits.
- TIMEOUT, 16: non-wait register cycles allowed per read before it completes on timeout; ≥2.
- FIFO_DEPTH, 4: response FIFO entries; power of two, ≥2.

Reset rstn, synchronous, active-low; clock clk.

- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- s_axil_araddr  in  ADDR_WIDTH  read address
- s_axil_arprot  in  3  ignored
- s_axil_arvalid  in  1  address valid
- s_axil_arready  out  1  address ready
- s_axil_rdata  out  DATA_WIDTH  read data (FIFO head)
- s_axil_rresp  out  2  response (FIFO head)
- s_axil_rvalid  out  1  FIFO non-empty
- s_axil_rready  in  1  master accepts response
- reg_rd_addr  out  ADDR_WIDTH  captured address
- reg_rd_en  out  1  register read request, level
- reg_rd_data  in  DATA_WIDTH  register data, sampled on completion
- reg_rd_wait  in  1  freezes timeout counter
- reg_rd_ack  in  1  register data valid this cycle
- rd_timeout  out  1  one-cycle pulse per timed-out read

## Operation
- FSM states: IDLE and REQ.
- s_axil_arready = (state==IDLE) && (fifo_count < FIFO_DEPTH).
- IDLE: on arvalid && arready:
  - capture araddr into reg_rd_addr;
  - load the timeout counter with TIMEOUT-1;
  - move to REQ.
- REQ: reg_rd_en=1. Completion is evaluated each cycle in this order:
  - reg_rd_ack=1: push {reg_rd_data, 2'b00}. Ack has priority over timeout in the same cycle.
  - else reg_rd_wait=0 and counter==0: timeout completion. Push the entry defined under Configuration and pulse rd_timeout.
  - else reg_rd_wait=0: counter decrements.
  - else (reg_rd_wait=1): counter holds; REQ can last indefinitely.
- Any completion returns the FSM to IDLE.
- Counter width is $clog2(TIMEOUT). It never underflows.
- At most one read is in flight. Accept is gated on FIFO space, so a push never overflows.
- Pop on s_axil_rvalid && s_axil_rready.
- Simultaneous push and pop: count unchanged, data order preserved.
- Pointers wrap modulo FIFO_DEPTH.
- arprot is ignored. reg_rd_addr holds its value outside REQ.

## Timing
- Reset values:
  - arready 0 during reset, 1 in the first cycle after reset;
  - rvalid 0, rdata 0, rresp 0;
  - reg_rd_en 0, reg_rd_addr 0, rd_timeout 0;
  - FIFO empty, state IDLE.
- Reset asserted mid-read: the in-flight read is dropped with no response, the FIFO is flushed and reg_rd_en drops on the next edge.
- AR handshake in cycle N: reg_rd_en=1 from N+1. Ack in N+1 gives rvalid=1 in N+2.
- Peak throughput: one read per 2 cycles, because arready is 0 while in REQ.
- Timeout: completes in the TIMEOUT-th REQ cycle with reg_rd_wait=0. rd_timeout is high in that same cycle; the entry is visible the next cycle.
- rdata and rresp come straight from FIFO registers, with no combinational path from reg_rd_*.
- Once rvalid is high it stays high, with stable data, until it is popped.

## Configuration
- AXIL_RD_TIMEOUT_SLVERR_EN defined: a timeout completion pushes {0, 2'b10 SLVERR}.
- Undefined: a timeout completion pushes {reg_rd_data sampled that cycle, 2'b00 OKAY}.
- rd_timeout pulses in both builds.

## Test plan
- Single read, ack in the first REQ cycle, rready=1:
  - araddr=0x10 in cycle N, reg_rd_data=0xDEADBEEF;
  - expect rvalid=1 at N+2 with rdata 0xDEADBEEF and rresp 00.
- rready=0 for 4 reads with FIFO_DEPTH=4, data 1..4:
  - arready stays 0 after the 4th push;
  - raising rready returns 1,2,3,4 in order, and arready returns after the first pop.
- No ack, reg_rd_wait=0, TIMEOUT=16:
  - rd_timeout pulses in the 16th REQ cycle;
  - with the macro defined: rresp=10, rdata=0;
  - without the macro: rresp=00, rdata=reg_rd_data.
- reg_rd_wait=1 for 100 cycles, then ack: no timeout, OKAY response, reg_rd_en high for 101 cycles.
- Ack and counter==0 in the same cycle: OKAY response and no rd_timeout pulse.
- rstn low while in REQ with 2 FIFO entries:
  - next cycle rvalid=0 and reg_rd_en=0;
  - no stale response appears after reset.
